// File: rtl/tensor_slice_param.sv
// tensor_slice_param: NxN signed int matmul tile with K-tiling accumulation,
// optional output saturation, ready/valid result and fixed-delay A/B chaining.
module tensor_slice_param #(
   parameter int N           = 8,
   parameter int DW          = 8,
   parameter int AW          = 32,
   parameter int OW          = 16,
   parameter int LATENCY     = 33,
   parameter int CHAIN_DEPTH = 33
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load_b,
   input  logic            b_valid,
   input  logic [N*DW-1:0] b_data,
   input  logic            start,
   input  logic [N*DW-1:0] a_data,
   input  logic            acc_en,
   input  logic            sat_en,
   output logic [N*OW-1:0] c_data_out,
   output logic            c_valid,
   input  logic            c_ready,
   output logic            done,
   output logic            busy,
   output logic [1:0]      flags,
   input  logic [N*DW-1:0] a_data_in,
   input  logic [N*DW-1:0] b_data_in,
   output logic [N*DW-1:0] a_data_out,
   output logic [N*DW-1:0] b_data_out
);

   localparam int CW = $clog2(LATENCY + 1);
   localparam int RW = $clog2(N + 1);
   localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
   localparam logic signed [AW-1:0] SMAX =
      AW'((64'sd1 <<< (OW - 1)) - 64'sd1);
   localparam logic signed [AW-1:0] SMIN = ~SMAX;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_COMP,
      S_OUT
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]          lat_cnt;
   logic [RW-1:0]          row_cnt;
   logic [N*DW-1:0]        b_mem   [N];
   logic [N*DW-1:0]        a_q;
   logic                   acc_en_q;
   logic                   sat_en_q;
   logic signed [AW-1:0]   acc     [N];
   logic signed [AW-1:0]   acc_nxt [N];
   logic signed [AW-1:0]   lane;
   logic [N*OW-1:0]        c_nxt;
   logic                   clip_nxt;
   logic                   sat_flag;
   logic                   drop_flag;
   logic [N*DW-1:0]        a_pipe  [CHAIN_DEPTH];
   logic [N*DW-1:0]        b_pipe  [CHAIN_DEPTH];

   logic accept, beat, lat_done, hs, drop;

   assign accept   = (state == S_IDLE) && start && !load_b;
   assign beat     = (state == S_LOAD) && b_valid;
   assign lat_done = (state == S_COMP) && (lat_cnt == '0);
   assign hs       = (state == S_OUT) && c_ready;
   assign drop     = start && ((state != S_IDLE) || load_b);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state decode; load_b wins over start in IDLE
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (load_b)     state_nxt = S_LOAD;
            else if (start) state_nxt = S_COMP;
         end
         S_LOAD: if (b_valid && row_cnt == ROW_LAST) state_nxt = S_IDLE;
         S_COMP: if (lat_cnt == '0) state_nxt = S_OUT;
         S_OUT:  if (c_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy    = (state != S_IDLE);
      c_valid = (state == S_OUT);
      flags   = {drop_flag, sat_flag};
   end

   // Latency down-counter and B row counter, both rearmed in IDLE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lat_cnt <= '0;
         row_cnt <= '0;
      end else begin
         if (state == S_IDLE) begin
            lat_cnt <= LAT_M1;
            row_cnt <= '0;
         end else begin
            if (state == S_COMP && lat_cnt != '0)
               lat_cnt <= lat_cnt - CW'(1);
            if (beat)
               row_cnt <= row_cnt + RW'(1);
         end
      end
   end

   // B tile store, one row per accepted beat
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < N; r++) b_mem[r] <= '0;
      end else begin
         for (int r = 0; r < N; r++)
            if (beat && row_cnt == RW'(r)) b_mem[r] <= b_data;
      end
   end

   // Per-lane dot product on top of the (optionally kept) accumulator
   always_comb begin
      lane = '0;
      for (int j = 0; j < N; j++) begin
         lane = acc_en_q ? acc[j] : '0;
         for (int k = 0; k < N; k++)
            lane = lane + AW'($signed(a_q[k*DW +: DW]) *
                              $signed(b_mem[k][j*DW +: DW]));
         acc_nxt[j] = lane;
      end
   end

   // Clamp or truncate each lane to the output width
   always_comb begin
      c_nxt    = '0;
      clip_nxt = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (sat_en_q && acc_nxt[j] > SMAX) begin
            c_nxt[j*OW +: OW] = SMAX[OW-1:0];
            clip_nxt = 1'b1;
         end else if (sat_en_q && acc_nxt[j] < SMIN) begin
            c_nxt[j*OW +: OW] = SMIN[OW-1:0];
            clip_nxt = 1'b1;
         end else begin
            c_nxt[j*OW +: OW] = acc_nxt[j][OW-1:0];
         end
      end
   end

   // Operand capture, result commit and status flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q        <= '0;
         acc_en_q   <= 1'b0;
         sat_en_q   <= 1'b0;
         c_data_out <= '0;
         sat_flag   <= 1'b0;
         drop_flag  <= 1'b0;
         done       <= 1'b0;
         for (int j = 0; j < N; j++) acc[j] <= '0;
      end else begin
         if (accept) begin
            a_q      <= a_data;
            acc_en_q <= acc_en;
            sat_en_q <= sat_en;
         end
         if (lat_done) begin
            for (int j = 0; j < N; j++) acc[j] <= acc_nxt[j];
            c_data_out <= c_nxt;
            sat_flag   <= clip_nxt;
         end
         if (drop) drop_flag <= 1'b1;
         done <= hs;
      end
   end

   // Free-running A/B chain delay lines
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHAIN_DEPTH; i++) begin
            a_pipe[i] <= '0;
            b_pipe[i] <= '0;
         end
      end else begin
         a_pipe[0] <= a_data_in;
         b_pipe[0] <= b_data_in;
         for (int i = 1; i < CHAIN_DEPTH; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
         end
      end
   end

   assign a_data_out = a_pipe[CHAIN_DEPTH-1];
   assign b_data_out = b_pipe[CHAIN_DEPTH-1];

endmodule

// File: tb/tb_tensor_slice_param.sv
// tb_tensor_slice_param: randomized self-checking bench for tensor_slice_param
// against a plain integer matrix model.
`timescale 1ns/1ps
module tb_tensor_slice_param;
   localparam int N   = 8;
   localparam int LAT = 33;
   localparam int CD  = 33;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          load_b = 1'b0;
   logic          b_valid = 1'b0;
   logic [63:0]   b_data = '0;
   logic          start = 1'b0;
   logic [63:0]   a_data = '0;
   logic          acc_en = 1'b0;
   logic          sat_en = 1'b0;
   logic [127:0]  c_data_out;
   logic          c_valid;
   logic          c_ready = 1'b0;
   logic          done;
   logic          busy;
   logic [1:0]    flags;
   logic [63:0]   a_data_in = '0;
   logic [63:0]   b_data_in = '0;
   logic [63:0]   a_data_out;
   logic [63:0]   b_data_out;

   int total = 0;
   int bad   = 0;

   int          bm   [N][N];
   int          macc [N];
   int          av   [N];
   logic [15:0] exp_c[N];
   bit          exp_clip;
   bit          drop_m;

   always #5 clk = ~clk;

   tensor_slice_param dut (
      .clk(clk), .reset_n(reset_n), .load_b(load_b), .b_valid(b_valid),
      .b_data(b_data), .start(start), .a_data(a_data), .acc_en(acc_en),
      .sat_en(sat_en), .c_data_out(c_data_out), .c_valid(c_valid),
      .c_ready(c_ready), .done(done), .busy(busy), .flags(flags),
      .a_data_in(a_data_in), .b_data_in(b_data_in),
      .a_data_out(a_data_out), .b_data_out(b_data_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd8();
      return int'($urandom_range(255)) - 128;
   endfunction

   // C = (acc_en ? C : 0) + A*B with 32-bit wrap, then clamp or truncate
   function automatic void model_op(bit ae, bit se);
      int s;
      exp_clip = 1'b0;
      for (int j = 0; j < N; j++) begin
         s = ae ? macc[j] : 0;
         for (int k = 0; k < N; k++) s += av[k] * bm[k][j];
         macc[j] = s;
         if (se && s > 32767) begin
            exp_c[j] = 16'h7fff;
            exp_clip = 1'b1;
         end else if (se && s < -32768) begin
            exp_c[j] = 16'h8000;
            exp_clip = 1'b1;
         end else begin
            exp_c[j] = s[15:0];
         end
      end
   endfunction

   function automatic logic [63:0] pack_a();
      logic [63:0] r;
      for (int k = 0; k < N; k++) r[k*8 +: 8] = av[k][7:0];
      return r;
   endfunction

   function automatic logic [127:0] pack_c();
      logic [127:0] r;
      for (int j = 0; j < N; j++) r[j*16 +: 16] = exp_c[j];
      return r;
   endfunction

   task automatic do_load(int gapmax, bit coincide);
      int g;
      load_b = 1'b1;
      start  = coincide;
      step();
      load_b = 1'b0;
      start  = 1'b0;
      if (coincide) drop_m = 1'b1;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL load_enter busy=%b want 1", busy);
      end
      for (int r = 0; r < N; r++) begin
         g = int'($urandom_range(gapmax));
         repeat (g) begin
            b_valid = 1'b0;
            b_data  = {$urandom(), $urandom()};
            step();
         end
         b_valid = 1'b1;
         for (int j = 0; j < N; j++) b_data[j*8 +: 8] = bm[r][j][7:0];
         step();
         b_valid = 1'b0;
         if (r == N - 2) begin
            total++;
            if (busy !== 1'b1) begin
               bad++;
               $display("FAIL load_7th busy=%b want 1", busy);
            end
         end
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL load_exit busy=%b want 0", busy);
      end
   endtask

   task automatic run_op(bit ae, bit se, int hold, bit poke);
      int          lat;
      bit          stable;
      logic [127:0] ev;
      a_data = pack_a();
      acc_en = ae;
      sat_en = se;
      start  = 1'b1;
      step();
      start  = 1'b0;
      a_data = {$urandom(), $urandom()};
      acc_en = ~ae;
      sat_en = ~se;
      model_op(ae, se);
      ev  = pack_c();
      lat = 0;
      do begin
         step();
         lat++;
      end while (c_valid !== 1'b1 && lat < 100);
      total++;
      if (lat != LAT) begin
         bad++;
         $display("FAIL op_latency got=%0d want %0d", lat, LAT);
      end
      total++;
      if (c_data_out !== ev) begin
         bad++;
         $display("FAIL op_data got=%h want %h", c_data_out, ev);
      end
      total++;
      if (flags !== {drop_m, exp_clip}) begin
         bad++;
         $display("FAIL op_flags got=%b want %b", flags, {drop_m, exp_clip});
      end
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         if (poke && i == 2) start = 1'b1;
         if (poke && i == 5) load_b = 1'b1;
         step();
         start  = 1'b0;
         load_b = 1'b0;
         if (c_valid !== 1'b1 || busy !== 1'b1 || c_data_out !== ev)
            stable = 1'b0;
      end
      if (poke) drop_m = 1'b1;
      if (hold > 0) begin
         total++;
         if (!stable) begin
            bad++;
            $display("FAIL hold_stable got=%h want %h", c_data_out, ev);
         end
         total++;
         if (flags[1] !== drop_m) begin
            bad++;
            $display("FAIL hold_drop got=%b want %b", flags[1], drop_m);
         end
      end
      c_ready = 1'b1;
      step();
      c_ready = 1'b0;
      total++;
      if ({c_valid, done, busy} !== 3'b010) begin
         bad++;
         $display("FAIL handshake v/d/b got=%b want 010",
                  {c_valid, done, busy});
      end
      total++;
      if (c_data_out !== ev) begin
         bad++;
         $display("FAIL retain got=%h want %h", c_data_out, ev);
      end
      step();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL done_pulse got=%b want 0", done);
      end
   endtask

   task automatic set_b_const(int v);
      for (int r = 0; r < N; r++)
         for (int j = 0; j < N; j++) bm[r][j] = v;
   endtask

   task automatic set_b_identity();
      for (int r = 0; r < N; r++)
         for (int j = 0; j < N; j++) bm[r][j] = (r == j) ? 1 : 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) step();
      total++;
      if ({c_valid, done, busy, flags} !== 5'b0 || c_data_out !== '0 ||
          a_data_out !== '0 || b_data_out !== '0) begin
         bad++;
         $display("FAIL reset_outs got=%b %h want 0",
                  {c_valid, done, busy, flags}, c_data_out);
      end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_identity();
      set_b_identity();
      do_load(3, 1'b0);
      for (int k = 0; k < N; k++) av[k] = k + 1;
      run_op(1'b0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_accumulate();
      set_b_const(2);
      do_load(2, 1'b0);
      for (int k = 0; k < N; k++) av[k] = -3;
      run_op(1'b0, 1'b0, 0, 1'b0);
      run_op(1'b1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_saturate();
      set_b_const(127);
      do_load(1, 1'b0);
      for (int k = 0; k < N; k++) av[k] = 127;
      run_op(1'b0, 1'b1, 0, 1'b0);
      run_op(1'b0, 1'b0, 0, 1'b0);
      for (int k = 0; k < N; k++) av[k] = -128;
      run_op(1'b0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < N; k++) av[k] = rnd8();
      run_op(1'b0, 1'b0, 10, 1'b1);
   endtask

   task automatic test_gapped_load();
      set_b_identity();
      do_load(5, 1'b1);
      for (int k = 0; k < N; k++) av[k] = rnd8();
      run_op(1'b0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_chain();
      logic [63:0] ha[$];
      logic [63:0] hb[$];
      logic [127:0] ev;
      int seen_at;
      seen_at = -1;
      ev = '0;
      c_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         a_data_in = (i == 0) ? 64'h0102030405060708 : {$urandom(), $urandom()};
         b_data_in = {$urandom(), $urandom()};
         if (i == 3) begin
            for (int k = 0; k < N; k++) av[k] = rnd8();
            a_data = pack_a();
            acc_en = 1'b0;
            sat_en = 1'b1;
            start  = 1'b1;
            model_op(1'b0, 1'b1);
            ev = pack_c();
         end
         step();
         start = 1'b0;
         ha.push_back(a_data_in);
         hb.push_back(b_data_in);
         if (i >= CD - 1) begin
            total++;
            if (a_data_out !== ha[i-(CD-1)] || b_data_out !== hb[i-(CD-1)]) begin
               bad++;
               $display("FAIL chain i=%0d got=%h/%h want %h/%h", i, a_data_out,
                        b_data_out, ha[i-(CD-1)], hb[i-(CD-1)]);
            end
         end
         if (c_valid === 1'b1 && seen_at < 0) begin
            seen_at = i;
            total++;
            if (c_data_out !== ev) begin
               bad++;
               $display("FAIL chain_op_data got=%h want %h", c_data_out, ev);
            end
         end
      end
      c_ready = 1'b0;
      total++;
      if (seen_at != 3 + LAT) begin
         bad++;
         $display("FAIL chain_op_latency got=%0d want %0d", seen_at, 3 + LAT);
      end
   endtask

   task automatic test_random();
      bit ae, se;
      for (int n = 0; n < 6; n++) begin
         if (n % 3 == 0) begin
            for (int r = 0; r < N; r++)
               for (int j = 0; j < N; j++) bm[r][j] = rnd8();
            do_load(2, 1'b0);
         end
         for (int k = 0; k < N; k++) av[k] = rnd8();
         ae = 1'(n > 0 && $urandom_range(1) == 1);
         se = 1'($urandom_range(1));
         run_op(ae, se, int'($urandom_range(3)), 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      bit quiet;
      for (int k = 0; k < N; k++) av[k] = rnd8();
      a_data = pack_a();
      a_data_in = {$urandom(), $urandom()} | 64'h1;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      reset_n = 1'b0;
      #1;
      total++;
      if ({c_valid, done, busy, flags} !== 5'b0 || c_data_out !== '0 ||
          a_data_out !== '0) begin
         bad++;
         $display("FAIL async_reset got=%b %h %h want 0",
                  {c_valid, done, busy, flags}, c_data_out, a_data_out);
      end
      for (int j = 0; j < N; j++) macc[j] = 0;
      set_b_const(0);
      drop_m = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      quiet = 1'b1;
      repeat (40) begin
         step();
         if (c_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      total++;
      if (!quiet) begin
         bad++;
         $display("FAIL post_reset_quiet valid=%b busy=%b want 0 0", c_valid, busy);
      end
      test_identity();
   endtask

   initial begin
      drop_m = 1'b0;
      for (int j = 0; j < N; j++) macc[j] = 0;
      set_b_const(0);
      test_reset();
      test_identity();
      test_accumulate();
      test_saturate();
      test_backpressure();
      test_gapped_load();
      test_chain();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
